// File: rtl/sat_sched_pkg.sv
// Shared types for the BCP scheduling blocks: sequencer states, default widths
// and the packed layout of a var-start-end RAM entry.
package sat_sched_pkg;

  localparam int SEQ_VAR_W  = 8;
  localparam int SEQ_CIDX_W = 13;

  typedef logic [SEQ_CIDX_W-1:0] cidx_t;

  typedef struct packed {
    cidx_t end_idx;
    cidx_t start_idx;
  } vse_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    VSE_RD,
    VSE_CAP,
    ISSUE,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/bcp_drain_timer.sv
// Down-counter that spans the evaluation pipeline drain after the last issue.
// load presets DRAIN_CYC; expire is high in the final drain cycle.
module bcp_drain_timer #(
  parameter int DRAIN_CYC = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int CNT_W = $clog2(DRAIN_CYC + 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= CNT_W'(DRAIN_CYC);
    end else if (count && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign expire = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/bcp_clause_sequencer.sv
// Walks one variable's clause-table range and issues a clause per cycle to eval_prep.
// Define BCP_SEQ_PERF_EN to add saturating perf_issued/perf_stall counters.
module bcp_clause_sequencer
  import sat_sched_pkg::*;
#(
  parameter int VAR_W     = SEQ_VAR_W,
  parameter int CIDX_W    = SEQ_CIDX_W,
  parameter int DRAIN_CYC = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [VAR_W-1:0]    var_idx,
  output logic [VAR_W-1:0]    vse_addr,
  input  logic [2*CIDX_W-1:0] vse_q,
  output logic [CIDX_W-1:0]   ct_addr,
  output logic                issue_en,
  input  logic                stall,
  input  logic                conflict,
  output logic                busy,
  output logic                done,
  output logic                aborted
`ifdef BCP_SEQ_PERF_EN
  ,
  output logic [31:0]         perf_issued,
  output logic [31:0]         perf_stall
`endif
);

  seq_state_t        state_reg, state_next;
  logic [CIDX_W-1:0] cur_reg, cur_next;
  logic [CIDX_W-1:0] last_reg, last_next;
  logic              abort_reg, abort_next;
  logic [VAR_W-1:0]  vse_addr_reg, vse_addr_next;
  logic              drain_load, drain_expire;
  logic [CIDX_W-1:0] q_start, q_end;

  assign q_start = vse_q[CIDX_W-1:0];
  assign q_end   = vse_q[2*CIDX_W-1:CIDX_W];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      cur_reg      <= '0;
      last_reg     <= '0;
      abort_reg    <= 1'b0;
      vse_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cur_reg      <= cur_next;
      last_reg     <= last_next;
      abort_reg    <= abort_next;
      vse_addr_reg <= vse_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cur_next      = cur_reg;
    last_next     = last_reg;
    abort_next    = abort_reg;
    vse_addr_next = vse_addr_reg;
    drain_load    = 1'b0;
    issue_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          vse_addr_next = var_idx;
          state_next    = VSE_RD;
        end
      end
      VSE_RD: begin
        if (conflict) begin
          abort_next = 1'b1;
          state_next = DONE;
        end else begin
          state_next = VSE_CAP;
        end
      end
      VSE_CAP: begin
        if (conflict) begin
          abort_next = 1'b1;
          state_next = DONE;
        end else begin
          cur_next   = q_start;
          last_next  = q_end;
          state_next = (q_start > q_end) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        // Conflict suppresses the issue in the same cycle; stall only holds.
        if (conflict) begin
          abort_next = 1'b1;
          drain_load = 1'b1;
          state_next = DRAIN;
        end else if (!stall) begin
          issue_en = 1'b1;
          if (cur_reg == last_reg) begin
            drain_load = 1'b1;
            state_next = DRAIN;
          end else begin
            cur_next = cur_reg + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (conflict) begin
          abort_next = 1'b1;
        end
        if (drain_expire) begin
          state_next = DONE;
        end
      end
      DONE: begin
        abort_next = 1'b0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  bcp_drain_timer #(
    .DRAIN_CYC(DRAIN_CYC)
  ) u_drain_timer (
    .clock (clock),
    .reset (reset),
    .load  (drain_load),
    .count (state_reg == DRAIN),
    .expire(drain_expire)
  );

  assign vse_addr = vse_addr_reg;
  assign ct_addr  = cur_reg;
  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign aborted  = (state_reg == DONE) && abort_reg;

`ifdef BCP_SEQ_PERF_EN
  logic [31:0] perf_issued_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_issued_reg <= '0;
      perf_stall_reg  <= '0;
    end else begin
      if (issue_en && (perf_issued_reg != '1)) begin
        perf_issued_reg <= perf_issued_reg + 1'b1;
      end
      if ((state_reg == ISSUE) && stall && (perf_stall_reg != '1)) begin
        perf_stall_reg <= perf_stall_reg + 1'b1;
      end
    end
  end

  assign perf_issued = perf_issued_reg;
  assign perf_stall  = perf_stall_reg;
`endif

endmodule
